bwn_xnor_dot: RTL and testbench
===============================

# bwn_xnor_dot

Binary-weight dot-product engine that consumes the 80-bit weight words of the BWN weight ROM. On `start` it latches one 80-bit binary activation vector. It then walks the ROM rows 0..N_ROWS-1 by driving `addr`. For each row it computes the XNOR-popcount dot product and streams one signed score per row downstream through a valid/ready handshake. It sits directly after the weight ROM, between the ROM and the activation/threshold stage.

## Interface
- `WIDTH_A`, 12, ROM address width.
- `N_ROWS`, 120, number of weight rows walked per run.
- `VEC_W`, 80, weight/activation word width.
- `SCORE_W`, 8, signed score width; must cover ±VEC_W.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `act`  in  VEC_W  activation vector (bit 1 = +1, bit 0 = −1); latched on accepted start.
- `addr`  out  WIDTH_A  ROM address; registered.
- `coef`  in  VEC_W  ROM data; combinational from `addr`, valid in the same cycle.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_row`  out  WIDTH_A  row index of the current result.
- `res_score`  out  SCORE_W  signed dot product for the row.
- `busy`  out  1  high from accepted start until the final result handshake.
- `done`  out  1  one-cycle pulse on the final result handshake.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - On `start=1`: `act_q<=act`, `addr<=0`, `busy<=1`, go to RUN.
  - `start` in any other state is ignored.
- **RUN**
  - Stage 1 advances when it is empty or stage 2 will take its content this cycle (stage 2 free, or `res_ready=1`).
  - On advance: `xn<=~(coef^act_q)`, `tag<=addr`, `v1<=1`.
  - If `addr==N_ROWS-1`: go to DRAIN and hold `addr`. Otherwise `addr<=addr+1`.
- **DRAIN**
  - Stage 1 issues nothing new (`v1` clears once its content moves on).
  - On the handshake of the result with `res_row==N_ROWS-1`: `done<=1` for one cycle, `busy<=0`, go to IDLE.
- **Stage 2 (output register)**
  - Loads from stage 1 when `!res_valid || res_ready`.
  - `res_score = 2*popcount(xn) − VEC_W`, computed in SCORE_W signed.
  - `res_row<=tag`, `res_valid<=v1`.
  - Output values are held stable while `res_valid && !res_ready`.
- **Arithmetic**
  - Popcount range 0..80, 7 bits unsigned.
  - Score range −80..+80; even values only when VEC_W is even.
- **Reset**
  - Values: `addr=0`, `res_valid=0`, `res_row=0`, `res_score=0`, `busy=0`, `done=0`, `v1=0`, `act_q=0`, state IDLE.
  - Reset asserted mid-run aborts the run with no `done`. In-flight results are discarded.
- **Boundaries**
  - `addr` never exceeds N_ROWS-1 and does not wrap.
  - `start` arriving in the same cycle as the final handshake is ignored: the FSM is still in DRAIN. It is accepted from the next IDLE cycle.

## Timing
- Start accepted at edge E0: `addr=0` after E0.
- Row 0 captured in stage 1 at E1; `res_valid=1` with row 0 after E2.
- Latency start→first result: 2 cycles.
- Throughput: 1 row/cycle with `res_ready` held high. A full run completes in N_ROWS+1 cycles after E0; `done` is high in the cycle after the row-119 handshake edge.
- Backpressure: at most 2 results are in flight (stage 1 and stage 2). `addr` freezes while stage 1 is blocked.

## Structure
- Package `bwn_pkg` holds:
  - VEC_W, N_ROWS, SCORE_W;
  - the state enum {IDLE, RUN, DRAIN};
  - the score function signature.
- Sub-module `bwn_popcount` (VEC_W in, 7-bit count out) is a purely combinational adder tree instantiated in stage 2.
- All other logic lives in the top module.

## Test plan
- Stub ROM with all rows = 0 and `act` = all-ones -> 120 results, rows 0..119 in order, every score −80, `done` pulses once.
- Real ROM with `act = 'h40C92A00B164044E689A` (row 0 word) -> row 0 score +80. With `act` = bitwise complement -> row 0 score −80. All rows match the reference model.
- Hold `res_ready=0` for 5 cycles after the first `res_valid` -> row 0 and its score stay stable, `addr` stops at 2, no results are lost. The remaining rows then flow at 1/cycle.
- Pulse `start` during RUN with a different `act` -> ignored: scores still match the first `act`, exactly 120 results.
- Drive `rst_n=0` for 1 cycle at row 50 -> all outputs return to reset values, no `done`. A new `start` afterwards produces rows 0..119.
- `start` coincident with the final handshake -> not accepted. `start` on the next cycle -> accepted, first result 2 cycles later.

Source files
------------

// File: rtl/bwn_pkg.sv
// Shared constants, FSM state type and score mapping for the binary-weight dot-product engine.
package bwn_pkg;
  localparam int VEC_W   = 80;
  localparam int N_ROWS  = 120;
  localparam int SCORE_W = 8;
  localparam int POP_W   = $clog2(VEC_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // score = 2*pop - VEC_W; modulo-2^SCORE_W arithmetic gives the right two's complement
  function automatic logic [SCORE_W-1:0] bwn_score(input logic [POP_W-1:0] pop);
    return SCORE_W'({pop, 1'b0}) - SCORE_W'(VEC_W);
  endfunction
endpackage

// File: rtl/bwn_popcount.sv
// Purpose: count of set bits in a VEC_W word (nibble counters, then a summing stage).
// Latency: purely combinational.
// Backpressure: none; follows its input.
module bwn_popcount #(
  parameter int VEC_W = 80,
  parameter int CNT_W = $clog2(VEC_W + 1)
) (
  input  logic [VEC_W-1:0] din,
  output logic [CNT_W-1:0] cnt
);
  localparam int NNIB = (VEC_W + 3) / 4;

  logic [4*NNIB-1:0] pad;
  logic [2:0]        nib [NNIB];

  always_comb begin
    pad = '0;
    pad[VEC_W-1:0] = din;
    for (int i = 0; i < NNIB; i++) begin
      nib[i] = 3'(pad[4*i]) + 3'(pad[4*i+1]) + 3'(pad[4*i+2]) + 3'(pad[4*i+3]);
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NNIB; i++) begin
      cnt = cnt + CNT_W'(nib[i]);
    end
  end
endmodule

// File: rtl/bwn_xnor_dot.sv
// Purpose: walk the weight ROM and stream one XNOR-popcount score per row for a latched activation.
// Latency: 2 cycles from accepted start to first result; 1 row/cycle with res_ready high.
// Backpressure: two-stage pipeline stalls on !res_ready; addr freezes while stage 1 is blocked.
module bwn_xnor_dot import bwn_pkg::*; #(
  parameter int WIDTH_A = 12,
  parameter int N_ROWS  = bwn_pkg::N_ROWS,
  parameter int VEC_W   = bwn_pkg::VEC_W,
  parameter int SCORE_W = bwn_pkg::SCORE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [VEC_W-1:0]   act,
  output logic [WIDTH_A-1:0] addr,
  input  logic [VEC_W-1:0]   coef,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH_A-1:0] res_row,
  output logic [SCORE_W-1:0] res_score,
  output logic               busy,
  output logic               done
);
  localparam logic [WIDTH_A-1:0] LAST = WIDTH_A'(N_ROWS - 1);

  state_t             state, state_n;
  logic [VEC_W-1:0]   act_q;
  logic [VEC_W-1:0]   xn;
  logic [WIDTH_A-1:0] tag;
  logic               v1;
  logic [POP_W-1:0]   pop;
  logic               ld2, adv1, last_hs;

  // stage 2 can take new content when empty or its result is leaving
  assign ld2     = !res_valid || res_ready;
  assign adv1    = (state == RUN) && (!v1 || ld2);
  assign last_hs = (state == DRAIN) && res_valid && res_ready && (res_row == LAST);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (adv1 && (addr == LAST)) state_n = DRAIN;
      DRAIN:   if (last_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr  <= '0;
      act_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      v1    <= 1'b0;
      xn    <= '0;
      tag   <= '0;
    end else begin
      done <= last_hs;
      busy <= (state_n != IDLE);
      if ((state == IDLE) && start) begin
        act_q <= act;
        addr  <= '0;
      end
      if (adv1) begin
        xn  <= ~(coef ^ act_q);
        tag <= addr;
        v1  <= 1'b1;
        if (addr != LAST) addr <= addr + 1'b1;
      end else if (ld2) begin
        v1 <= 1'b0;
      end
    end
  end

  bwn_popcount #(.VEC_W(VEC_W), .CNT_W(POP_W)) u_pop (
    .din (xn),
    .cnt (pop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_row   <= '0;
      res_score <= '0;
    end else if (ld2) begin
      res_valid <= v1;
      res_row   <= tag;
      res_score <= bwn_score(pop);
    end
  end
endmodule

// File: tb/tb_bwn_xnor_dot.sv
// Directed bench for bwn_xnor_dot with a stub/pattern ROM driven combinationally from addr.
module tb_bwn_xnor_dot;
  localparam logic [79:0] ROW0 = 80'h40C92A00B164044E689A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        res_ready = 1'b1;
  logic [79:0] act = '0;
  logic [79:0] coef;
  logic [11:0] addr, res_row;
  logic [7:0]  res_score;
  logic        res_valid, busy, done;
  logic        rom_zero = 1'b1;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  function automatic logic [79:0] rom_word(input logic [11:0] r);
    logic [15:0] x;
    x = 16'(r);
    return ROW0 ^ {x, 16'(x * 3), 16'(x * 7), 16'(x * 11), 16'(x * 13)};
  endfunction

  function automatic logic [7:0] exp_score(input logic [11:0] r, input logic [79:0] a);
    logic [79:0] w;
    int p;
    w = rom_zero ? 80'h0 : rom_word(r);
    p = $countones(~(w ^ a));
    return 8'(2 * p - 80);
  endfunction

  assign coef = rom_zero ? 80'h0 : rom_word(addr);

  bwn_xnor_dot dut (
    .clk(clk), .rst_n(rst_n), .start(start), .act(act), .addr(addr), .coef(coef),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_score(res_score),
    .busy(busy), .done(done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [79:0] a);
    act = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b1;
    repeat (3) tick();
    checks++; if (addr !== 12'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (res_row !== 12'd0) begin failures++; $display("FAIL reset_row got=%0d exp=0", res_row); end
    checks++; if (res_score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0h exp=0", res_score); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_rom;
    logic [79:0] a;
    int n, dn, over;
    a = '1; rom_zero = 1'b1; n = 0; dn = 0; over = 0;
    kick(a);
    checks++; if (busy !== 1'b1 || addr !== 12'd0 || res_valid !== 1'b0) begin
      failures++; $display("FAIL zero_e0 busy/addr/valid got=%b/%0d/%b exp=1/0/0", busy, addr, res_valid); end
    tick();
    checks++; if (res_valid !== 1'b0 || addr !== 12'd1) begin
      failures++; $display("FAIL zero_e1 valid/addr got=%b/%0d exp=0/1", res_valid, addr); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_row !== 12'd0 || res_score !== 8'hB0) begin
      failures++; $display("FAIL zero_latency valid/row/score got=%b/%0d/%0h exp=1/0/b0", res_valid, res_row, res_score); end
    for (int c = 0; c < 400 && dn == 0; c++) begin
      if (addr > 12'd119) over++;
      if (res_valid) begin
        checks++;
        if (res_row !== 12'(n) || res_score !== exp_score(12'(n), a)) begin
          failures++; $display("FAIL zero_row got=%0d/%0h exp=%0d/%0h", res_row, res_score, n, exp_score(12'(n), a)); end
        n++;
      end
      tick();
      if (done) dn++;
    end
    checks++; if (n != 120 || dn != 1 || over != 0) begin
      failures++; $display("FAIL zero_count results/done/addr_over got=%0d/%0d/%0d exp=120/1/0", n, dn, over); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || addr !== 12'd119) begin
      failures++; $display("FAIL zero_after done/busy/addr got=%b/%b/%0d exp=0/0/119", done, busy, addr); end
  endtask

  task automatic test_real_rom;
    logic [79:0] a;
    int n, dn;
    rom_zero = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? ROW0 : ~ROW0;
      n = 0; dn = 0;
      kick(a);
      tick(); tick();
      checks++; if (res_valid !== 1'b1 || res_row !== 12'd0 || res_score !== ((k == 0) ? 8'h50 : 8'hB0)) begin
        failures++; $display("FAIL real_row0 k=%0d valid/row/score got=%b/%0d/%0h exp=1/0/%0h", k, res_valid, res_row, res_score, (k == 0) ? 8'h50 : 8'hB0); end
      for (int c = 0; c < 400 && dn == 0; c++) begin
        if (res_valid) begin
          checks++;
          if (res_row !== 12'(n) || res_score !== exp_score(12'(n), a)) begin
            failures++; $display("FAIL real_row got=%0d/%0h exp=%0d/%0h", res_row, res_score, n, exp_score(12'(n), a)); end
          n++;
        end
        tick();
        if (done) dn++;
      end
      checks++; if (n != 120 || dn != 1) begin
        failures++; $display("FAIL real_count k=%0d results/done got=%0d/%0d exp=120/1", k, n, dn); end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [79:0] a;
    int n, dn, gaps;
    a = ROW0; rom_zero = 1'b0; n = 0; dn = 0; gaps = 0;
    kick(a);
    tick(); tick();
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (res_valid !== 1'b1 || res_row !== 12'd0 || res_score !== 8'h50 || addr !== 12'd2) begin
        failures++; $display("FAIL bp_hold c=%0d valid/row/score/addr got=%b/%0d/%0h/%0d exp=1/0/50/2", c, res_valid, res_row, res_score, addr); end
    end
    res_ready = 1'b1;
    for (int c = 0; c < 400 && dn == 0; c++) begin
      if (res_valid) begin
        checks++;
        if (res_row !== 12'(n) || res_score !== exp_score(12'(n), a)) begin
          failures++; $display("FAIL bp_row got=%0d/%0h exp=%0d/%0h", res_row, res_score, n, exp_score(12'(n), a)); end
        n++;
      end else if (n > 0 && n < 120) begin
        gaps++;
      end
      tick();
      if (done) dn++;
    end
    checks++; if (n != 120 || dn != 1 || gaps != 0) begin
      failures++; $display("FAIL bp_count results/done/gaps got=%0d/%0d/%0d exp=120/1/0", n, dn, gaps); end
    tick();
  endtask

  task automatic test_start_ignored;
    logic [79:0] a;
    int n, dn;
    a = ROW0; rom_zero = 1'b0; n = 0; dn = 0;
    kick(a);
    for (int c = 0; c < 400 && dn == 0; c++) begin
      if (res_valid) begin
        checks++;
        if (res_row !== 12'(n) || res_score !== exp_score(12'(n), a)) begin
          failures++; $display("FAIL ign_row got=%0d/%0h exp=%0d/%0h", res_row, res_score, n, exp_score(12'(n), a)); end
        n++;
      end
      start = (n == 11);
      act = start ? ~a : a;
      tick();
      if (done) dn++;
    end
    start = 1'b0;
    checks++; if (n != 120 || dn != 1) begin
      failures++; $display("FAIL ign_count results/done got=%0d/%0d exp=120/1", n, dn); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_run;
    logic [79:0] a;
    int n, dn, found, stray;
    a = ~ROW0; rom_zero = 1'b0; n = 0; dn = 0; found = 0; stray = 0;
    kick(a);
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (res_valid && res_row == 12'd50) found = 1;
      else tick();
    end
    checks++; if (found != 1) begin failures++; $display("FAIL rst_reach row50 got=%0d exp=1", found); end
    rst_n = 1'b0;
    tick();
    checks++; if (addr !== 12'd0 || res_valid !== 1'b0 || res_row !== 12'd0 || res_score !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL rst_mid addr/valid/row/score/busy/done got=%0d/%b/%0d/%0h/%b/%b exp=0/0/0/0/0/0",
                           addr, res_valid, res_row, res_score, busy, done); end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || busy || res_valid) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL rst_quiet stray_cycles got=%0d exp=0", stray); end
    kick(a);
    for (int c = 0; c < 400 && dn == 0; c++) begin
      if (res_valid) begin
        checks++;
        if (res_row !== 12'(n) || res_score !== exp_score(12'(n), a)) begin
          failures++; $display("FAIL rst_row got=%0d/%0h exp=%0d/%0h", res_row, res_score, n, exp_score(12'(n), a)); end
        n++;
      end
      tick();
      if (done) dn++;
    end
    checks++; if (n != 120 || dn != 1) begin
      failures++; $display("FAIL rst_count results/done got=%0d/%0d exp=120/1", n, dn); end
    tick();
  endtask

  task automatic test_start_at_final;
    int found, dn;
    rom_zero = 1'b0; found = 0; dn = 0;
    kick(ROW0);
    for (int c = 0; c < 300 && found == 0; c++) begin
      if (res_valid && res_row == 12'd119) found = 1;
      else tick();
    end
    checks++; if (found != 1) begin failures++; $display("FAIL fin_reach row119 got=%0d exp=1", found); end
    act = ~ROW0;
    start = 1'b1;
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL fin_coincident done/busy got=%b/%b exp=1/0", done, busy); end
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || addr !== 12'd0 || done !== 1'b0) begin
      failures++; $display("FAIL fin_next busy/addr/done got=%b/%0d/%b exp=1/0/0", busy, addr, done); end
    tick(); tick();
    checks++; if (res_valid !== 1'b1 || res_row !== 12'd0 || res_score !== 8'hB0) begin
      failures++; $display("FAIL fin_first valid/row/score got=%b/%0d/%0h exp=1/0/b0", res_valid, res_row, res_score); end
    for (int c = 0; c < 400 && dn == 0; c++) begin
      tick();
      if (done) dn++;
    end
    checks++; if (dn != 1) begin failures++; $display("FAIL fin_rundone done got=%0d exp=1", dn); end
  endtask

  initial begin
    test_reset();
    test_zero_rom();
    test_real_rom();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_run();
    test_start_at_final();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
